// File: rtl/fpcvt_pkg.sv
// Shared widths and FSM encoding for the FPCVT converter family.
// Used by the sequential normalizer and the upstream S/M stage.
// No logic lives here, only types and constants.
package fpcvt_pkg;

  localparam int MAG_W     = 11;
  localparam int EXP_W     = 3;
  localparam int SIG_W     = 4;
  localparam int MAX_SHIFT = 7;
  localparam int CNT_W     = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/fp_round.sv
// Rounds a raw exponent/significand pair by one round bit (round-half-up).
// Latency: purely combinational.
// Backpressure: none; a significand overflow bumps the exponent, and an exponent overflow saturates.
module fp_round
  import fpcvt_pkg::*;
(
  input  logic [EXP_W-1:0] Eraw,
  input  logic [SIG_W-1:0] Fraw,
  input  logic             r,
  output logic [EXP_W-1:0] E,
  output logic [SIG_W-1:0] F
);

  // Round-up with carry into the exponent; an all-ones result stays all-ones.
  always_comb begin
    E = Eraw;
    F = Fraw;
    if (r) begin
      if (Fraw != {SIG_W{1'b1}}) begin
        F = Fraw + SIG_W'(1);
      end else if (Eraw != {EXP_W{1'b1}}) begin
        E = Eraw + EXP_W'(1);
        F = {1'b1, {(SIG_W-1){1'b0}}};
      end
    end
  end

endmodule

// File: rtl/fp_normalize_seq.sv
// Normalizes an 11-bit sign-magnitude value to S/E(3)/F(4) by iterative left shifts, then rounds.
// Latency: n+2 cycles from accept to out_valid, where n (0..7) is the shift count.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE, no skid buffer.
module fp_normalize_seq
  import fpcvt_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             S,
  input  logic [MAG_W-1:0] M,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             S_out,
  output logic [EXP_W-1:0] E,
  output logic [SIG_W-1:0] F
);

  state_t             state_q, state_d;
  logic [MAG_W-1:0]   w_q, w_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               s_q, s_d;
  logic [EXP_W-1:0]   e_q, e_d;
  logic [SIG_W-1:0]   f_q, f_d;

  logic [EXP_W-1:0]   e_raw;
  logic [SIG_W-1:0]   f_raw;
  logic               rnd_bit;
  logic [EXP_W-1:0]   e_rnd;
  logic [SIG_W-1:0]   f_rnd;
  logic               shift_done;

  // Exponent counts down from the top as the value is shifted left; the
  // significand is the top SIG_W bits of the working register, round bit below it.
  assign e_raw      = EXP_W'(MAX_SHIFT) - cnt_q;
  assign f_raw      = w_q[MAG_W-1 -: SIG_W];
  assign rnd_bit    = w_q[MAG_W-1-SIG_W];
  assign shift_done = w_q[MAG_W-1] || (cnt_q == CNT_W'(MAX_SHIFT));

  fp_round u_round (
    .Eraw (e_raw),
    .Fraw (f_raw),
    .r    (rnd_bit),
    .E    (e_rnd),
    .F    (f_rnd)
  );

  // Next-state and datapath updates; everything holds unless its state acts on it.
  always_comb begin
    state_d  = state_q;
    w_d      = w_q;
    cnt_d    = cnt_q;
    s_d      = s_q;
    e_d      = e_q;
    f_d      = f_q;
    in_ready = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_d     = M;
          cnt_d   = '0;
          s_d     = S;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (shift_done) begin
          state_d = ROUND;
        end else begin
          w_d   = w_q << 1;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ROUND: begin
        e_d     = e_rnd;
        f_d     = f_rnd;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      w_q     <= '0;
      cnt_q   <= '0;
      s_q     <= 1'b0;
      e_q     <= '0;
      f_q     <= '0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      e_q     <= e_d;
      f_q     <= f_d;
    end
  end

  assign out_valid = (state_q == DONE);
  assign S_out     = s_q;
  assign E         = e_q;
  assign F         = f_q;

endmodule
